// File: rtl/elevator_pkg.sv
// Shared elevator constants: default floor count, end-floor indices and the
// hall-call validity masks reused by the controller and display blocks.
package elevator_pkg;

  localparam int NUM_FLOORS   = 4;
  localparam int MAX_FLOORS   = 32;
  localparam int TOP_FLOOR    = NUM_FLOORS - 1;
  localparam int BOTTOM_FLOOR = 0;

  // An up call from the top floor and a down call from the bottom floor are meaningless.
  function automatic logic [MAX_FLOORS-1:0] up_valid_bits(input int floors);
    logic [MAX_FLOORS-1:0] mask;
    mask            = '1;
    mask[floors-1]  = 1'b0;
    return mask;
  endfunction

  function automatic logic [MAX_FLOORS-1:0] down_valid_bits(input int floors);
    logic [MAX_FLOORS-1:0] mask;
    mask               = '1;
    mask[BOTTOM_FLOOR] = 1'b0;
    return mask;
  endfunction

  localparam logic [NUM_FLOORS-1:0] UP_VALID_MASK   = NUM_FLOORS'(up_valid_bits(NUM_FLOORS));
  localparam logic [NUM_FLOORS-1:0] DOWN_VALID_MASK = NUM_FLOORS'(down_valid_bits(NUM_FLOORS));

endpackage

// File: rtl/elevator_btn_cond.sv
// Single-button conditioner: 2-flop synchroniser, optional debounce filter
// (ELEVATOR_INPUT_DEBOUNCE_EN) and registered rising-edge detect -> press pulse.
module elevator_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic [1:0] sync_q;
  logic       level;
  logic       edge_q;
  logic       press_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

`ifdef ELEVATOR_INPUT_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             filt_q;

  // Count consecutive samples that disagree with the accepted level; any agreeing
  // sample restarts the count, so short glitches never reach the edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[1] == filt_q) begin
      cnt_q  <= '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt_q  <= '0;
      filt_q <= sync_q[1];
    end else begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign level = filt_q;
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = (DEBOUNCE_CYCLES > 0);
  assign level = sync_q[1];
`endif

  // edge_q starts at 0 after reset, so a button still held through reset yields one press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      edge_q  <= level;
      press_q <= level & ~edge_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/elevator_req_input.sv
// Request capture for the elevator: conditions every hall/car button and holds
// sticky request queues until cleared. Debounce enabled by ELEVATOR_INPUT_DEBOUNCE_EN.
module elevator_req_input
  import elevator_pkg::*;
#(
  parameter int FLOORS          = NUM_FLOORS,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] outsideUp,
  input  logic [FLOORS-1:0] outsideDown,
  input  logic [FLOORS-1:0] insideFloor,
  input  logic [FLOORS-1:0] clearUp,
  input  logic [FLOORS-1:0] clearDown,
  input  logic [FLOORS-1:0] clearInside,
  output logic [FLOORS-1:0] queueUp,
  output logic [FLOORS-1:0] queueDown,
  output logic [FLOORS-1:0] queueinside
);

  localparam logic [FLOORS-1:0] UP_MASK   = FLOORS'(up_valid_bits(FLOORS));
  localparam logic [FLOORS-1:0] DOWN_MASK = FLOORS'(down_valid_bits(FLOORS));

  logic [FLOORS-1:0] press_up;
  logic [FLOORS-1:0] press_down;
  logic [FLOORS-1:0] press_inside;

  logic [FLOORS-1:0] up_q;
  logic [FLOORS-1:0] down_q;
  logic [FLOORS-1:0] inside_q;

  for (genvar i = 0; i < FLOORS; i++) begin : g_floor
    elevator_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (outsideUp[i]),
      .press (press_up[i])
    );

    elevator_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (outsideDown[i]),
      .press (press_down[i])
    );

    elevator_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inside (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (insideFloor[i]),
      .press (press_inside[i])
    );
  end

  // Set is OR-ed after the clear so a press colliding with a clear keeps the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q     <= '0;
      down_q   <= '0;
      inside_q <= '0;
    end else begin
      up_q     <= ((up_q & ~clearUp) | press_up) & UP_MASK;
      down_q   <= ((down_q & ~clearDown) | press_down) & DOWN_MASK;
      inside_q <= (inside_q & ~clearInside) | press_inside;
    end
  end

  assign queueUp     = up_q;
  assign queueDown   = down_q;
  assign queueinside = inside_q;

endmodule

// File: tb/tb_elevator_req_input.sv
// Directed self-checking bench for elevator_req_input; press latency follows
// the ELEVATOR_INPUT_DEBOUNCE_EN build setting.
module tb_elevator_req_input;

`ifdef ELEVATOR_INPUT_DEBOUNCE_EN
  localparam int LAT = 4 + 4;
`else
  localparam int LAT = 4;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] outsideUp;
  logic [3:0] outsideDown;
  logic [3:0] insideFloor;
  logic [3:0] clearUp;
  logic [3:0] clearDown;
  logic [3:0] clearInside;
  logic [3:0] queueUp;
  logic [3:0] queueDown;
  logic [3:0] queueinside;

  int tests;
  int fails;

  elevator_req_input #(.FLOORS(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .outsideUp   (outsideUp),
    .outsideDown (outsideDown),
    .insideFloor (insideFloor),
    .clearUp     (clearUp),
    .clearDown   (clearDown),
    .clearInside (clearInside),
    .queueUp     (queueUp),
    .queueDown   (queueDown),
    .queueinside (queueinside)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are driven and outputs sampled here.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_all();
    clearUp = 4'hF; clearDown = 4'hF; clearInside = 4'hF;
    tick();
    clearUp = '0; clearDown = '0; clearInside = '0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    outsideUp = 4'hF; outsideDown = 4'hF; insideFloor = 4'hF;
    clearUp = '0; clearDown = '0; clearInside = '0;
    #2;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++;
      if ({queueUp, queueDown, queueinside} !== 12'h000) begin
        fails++;
        $display("FAIL reset_hold[%0d]: got %h expected 000", c, {queueUp, queueDown, queueinside});
      end
    end
    outsideUp = '0; outsideDown = '0; insideFloor = '0;
    rst_n = 1'b1;
    tick(10);
    tests++;
    if ({queueUp, queueDown, queueinside} !== 12'h000) begin
      fails++;
      $display("FAIL reset_release: got %h expected 000", {queueUp, queueDown, queueinside});
    end
  endtask

  task automatic test_single_call();
    tick(1000);
    outsideUp = 4'b0010;
    tick(LAT - 1);
    tests++;
    if (queueUp !== 4'b0000) begin
      fails++;
      $display("FAIL single_early: queueUp got %b expected 0000", queueUp);
    end
    tick();
    tests++;
    if (queueUp !== 4'b0010) begin
      fails++;
      $display("FAIL single_latency: queueUp got %b expected 0010", queueUp);
    end
    tick(50 - LAT);
    outsideUp = '0;
    tick(20);
    tests++;
    if ({queueUp, queueDown, queueinside} !== 12'b0010_0000_0000) begin
      fails++;
      $display("FAIL single_sticky: got %b expected 001000000000", {queueUp, queueDown, queueinside});
    end
    clearUp = 4'b0010;
    tick();
    clearUp = '0;
    tests++;
    if (queueUp !== 4'b0000) begin
      fails++;
      $display("FAIL single_clear: queueUp got %b expected 0000", queueUp);
    end
  endtask

  task automatic test_clear();
    insideFloor = 4'b0100;
    tick(LAT + 2);
    insideFloor = '0;
    tick(LAT + 2);
    tests++;
    if (queueinside !== 4'b0100) begin
      fails++;
      $display("FAIL clear_setup: queueinside got %b expected 0100", queueinside);
    end
    clearInside = 4'b0100;
    tick();
    clearInside = '0;
    tests++;
    if (queueinside !== 4'b0000) begin
      fails++;
      $display("FAIL clear_pulse: queueinside got %b expected 0000", queueinside);
    end
    tick(10);
    tests++;
    if (queueinside !== 4'b0000) begin
      fails++;
      $display("FAIL clear_stays: queueinside got %b expected 0000", queueinside);
    end
  endtask

  task automatic test_collision();
    insideFloor = 4'b0010;
    tick(LAT - 1);
    clearInside = 4'b0010;
    tick();
    clearInside = '0;
    tests++;
    if (queueinside !== 4'b0010) begin
      fails++;
      $display("FAIL collision_set_wins: queueinside got %b expected 0010", queueinside);
    end
    tick(5);
    insideFloor = '0;
    tick(LAT + 2);
    clear_all();
  endtask

  task automatic test_masked();
    outsideUp = 4'b1000;
    outsideDown = 4'b0001;
    tick(50);
    tests++;
    if ({queueUp, queueDown} !== 8'h00) begin
      fails++;
      $display("FAIL masked_calls: up/down got %b expected 00000000", {queueUp, queueDown});
    end
    outsideUp = '0;
    outsideDown = '0;
    tick(LAT + 2);
  endtask

  task automatic test_debounce();
`ifdef ELEVATOR_INPUT_DEBOUNCE_EN
    insideFloor = 4'b1000;
    tick(2);
    insideFloor = '0;
    tick(20);
    tests++;
    if (queueinside !== 4'b0000) begin
      fails++;
      $display("FAIL debounce_glitch: queueinside got %b expected 0000", queueinside);
    end
`endif
    insideFloor = 4'b1000;
    tick(LAT - 1);
    tests++;
    if (queueinside !== 4'b0000) begin
      fails++;
      $display("FAIL press_early: queueinside got %b expected 0000", queueinside);
    end
    tick();
    tests++;
    if (queueinside !== 4'b1000) begin
      fails++;
      $display("FAIL press_10cyc: queueinside got %b expected 1000", queueinside);
    end
    tick(10 - LAT > 0 ? 10 - LAT : 1);
    insideFloor = '0;
    tick(LAT + 2);
    clear_all();
  endtask

  task automatic test_concurrent();
    outsideUp = 4'b0001;
    outsideDown = 4'b0100;
    insideFloor = 4'b1010;
    tick(LAT - 1);
    tests++;
    if ({queueUp, queueDown, queueinside} !== 12'h000) begin
      fails++;
      $display("FAIL concurrent_early: got %b expected 000000000000", {queueUp, queueDown, queueinside});
    end
    tick();
    tests++;
    if ({queueUp, queueDown, queueinside} !== 12'b0001_0100_1010) begin
      fails++;
      $display("FAIL concurrent_same_edge: got %b expected 000101001010", {queueUp, queueDown, queueinside});
    end
    outsideUp = '0; outsideDown = '0; insideFloor = '0;
    tick(LAT + 2);
    clearDown = 4'b0100;
    tick();
    clearDown = '0;
    tests++;
    if ({queueUp, queueDown, queueinside} !== 12'b0001_0000_1010) begin
      fails++;
      $display("FAIL concurrent_clear_down: got %b expected 000100001010", {queueUp, queueDown, queueinside});
    end
    clear_all();
  endtask

  task automatic test_reset_mid_press();
    insideFloor = 4'b0001;
    tick(LAT + 2);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (queueinside !== 4'b0000) begin
      fails++;
      $display("FAIL reset_async: queueinside got %b expected 0000", queueinside);
    end
    tick(3);
    rst_n = 1'b1;
    tick(LAT - 1);
    tests++;
    if (queueinside !== 4'b0000) begin
      fails++;
      $display("FAIL held_after_reset_early: queueinside got %b expected 0000", queueinside);
    end
    tick();
    tests++;
    if (queueinside !== 4'b0001) begin
      fails++;
      $display("FAIL held_after_reset: queueinside got %b expected 0001", queueinside);
    end
    insideFloor = '0;
    tick(LAT + 2);
    clear_all();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_call();
    test_clear();
    test_collision();
    test_masked();
    test_debounce();
    test_concurrent();
    test_reset_mid_press();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
